// File: rtl/stream_serializer.sv
// Parametrised valid/ready word-to-beat serializer with a one-word staging buffer.
// Emits each D*S-bit word as S D-bit beats, gapless back to back, with idle fill and an underrun flag.
module stream_serializer #(
    parameter int             D            = 8,
    parameter int             S            = 4,
    parameter int             MSB_FIRST    = 0,
    parameter logic [D-1:0]   IDLE_PATTERN = '0
) (
    input  logic             high_speed_clock,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [D*S-1:0]   data_in,
    input  logic             clear_underrun,
    output logic [D-1:0]     data_out,
    output logic             out_valid,
    output logic             frame_start,
    output logic             underrun
);

    localparam int              CW       = (S > 1) ? $clog2(S) : 1;
    localparam logic [CW-1:0]   LAST_IDX = CW'(S - 1);

    typedef enum logic [1:0] {
        ACT_IDLE,
        ACT_LOAD,
        ACT_SHIFT
    } action_e;

    action_e          action;
    logic             load_now;
    logic             accept;

    logic             stg_valid_q,   stg_valid_d;
    logic [D*S-1:0]   stg_word_q,    stg_word_d;
    logic [D*S-1:0]   act_word_q,    act_word_d;
    logic [CW-1:0]    beat_idx_q,    beat_idx_d;
    logic [CW-1:0]    beats_left_q,  beats_left_d;
    logic [D-1:0]     data_out_q,    data_out_d;
    logic             out_valid_q,   out_valid_d;
    logic             frame_start_q, frame_start_d;
    logic             underrun_q,    underrun_d;

    // Beat k of a word; the ordering is fixed at elaboration by MSB_FIRST.
    function automatic logic [D-1:0] pick_beat(input logic [D*S-1:0] word,
                                               input logic [CW-1:0]  k);
        int             pos;
        logic [D*S-1:0] shifted;
        pos     = (MSB_FIRST != 0) ? (S - 1 - int'(k)) : int'(k);
        shifted = word >> (pos * D);
        return shifted[D-1:0];
    endfunction

    function automatic logic [CW-1:0] next_idx(input logic [CW-1:0] k);
        return (k == LAST_IDX) ? '0 : k + CW'(1);
    endfunction

    assign load_now = (beats_left_q == '0) && stg_valid_q;
    assign in_ready = !stg_valid_q || load_now;
    assign accept   = in_valid && in_ready;

    always_comb begin
        if (load_now) begin
            action = ACT_LOAD;
        end else if (beats_left_q != '0) begin
            action = ACT_SHIFT;
        end else begin
            action = ACT_IDLE;
        end
    end

    // NOTE: every next-state signal takes its hold value first, so no path through this block can infer a latch.
    always_comb begin
        stg_valid_d   = stg_valid_q;
        stg_word_d    = stg_word_q;
        act_word_d    = act_word_q;
        beat_idx_d    = beat_idx_q;
        beats_left_d  = beats_left_q;
        data_out_d    = data_out_q;
        out_valid_d   = out_valid_q;
        frame_start_d = frame_start_q;
        underrun_d    = underrun_q;

        case (action)
            ACT_LOAD: begin
                act_word_d    = stg_word_q;
                data_out_d    = pick_beat(stg_word_q, '0);
                out_valid_d   = 1'b1;
                frame_start_d = 1'b1;
                beat_idx_d    = next_idx('0);
                beats_left_d  = LAST_IDX;
                stg_valid_d   = 1'b0;
            end
            ACT_SHIFT: begin
                data_out_d    = pick_beat(act_word_q, beat_idx_q);
                out_valid_d   = 1'b1;
                frame_start_d = 1'b0;
                beat_idx_d    = next_idx(beat_idx_q);
                beats_left_d  = beats_left_q - CW'(1);
            end
            default: begin
                data_out_d    = IDLE_PATTERN;
                out_valid_d   = 1'b0;
                frame_start_d = 1'b0;
            end
        endcase

        // A word accepted on the same edge as a load refills the staging slot.
        if (accept) begin
            stg_word_d  = data_in;
            stg_valid_d = 1'b1;
        end

        if (out_valid_q && !out_valid_d) begin
            underrun_d = 1'b1;
        end else if (clear_underrun) begin
            underrun_d = 1'b0;
        end
    end

    // NOTE: sequential state is written with non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge high_speed_clock or posedge reset) begin
        if (reset) begin
            stg_valid_q   <= 1'b0;
            beat_idx_q    <= '0;
            beats_left_q  <= '0;
            data_out_q    <= IDLE_PATTERN;
            out_valid_q   <= 1'b0;
            frame_start_q <= 1'b0;
            underrun_q    <= 1'b0;
        end else begin
            stg_valid_q   <= stg_valid_d;
            beat_idx_q    <= beat_idx_d;
            beats_left_q  <= beats_left_d;
            data_out_q    <= data_out_d;
            out_valid_q   <= out_valid_d;
            frame_start_q <= frame_start_d;
            underrun_q    <= underrun_d;
        end
    end

    // NOTE: word storage is not reset; the valid flag and beat counter alone decide whether it is ever used.
    always_ff @(posedge high_speed_clock) begin
        stg_word_q <= stg_word_d;
        act_word_q <= act_word_d;
    end

    assign data_out    = data_out_q;
    assign out_valid   = out_valid_q;
    assign frame_start = frame_start_q;
    assign underrun    = underrun_q;

endmodule

// File: tb/tb_stream_serializer.sv
// Self-checking bench: four serializer configurations run in lockstep against a
// timestamp-scheduled reference model (each word owns edges start..start+S-1).
module tb_stream_serializer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        in_valid  [4];
    logic [31:0] data_in   [4];
    logic        clear_und [4];

    logic       rdy0, rdy1, rdy2, rdy3;
    logic [7:0] dout0, dout1, dout3;
    logic [3:0] dout2;
    logic       ov0, ov1, ov2, ov3;
    logic       fs0, fs1, fs2, fs3;
    logic       ur0, ur1, ur2, ur3;

    stream_serializer #(.D(8), .S(4), .MSB_FIRST(0), .IDLE_PATTERN(8'hA5)) u0 (
        .high_speed_clock(clk), .reset(reset), .in_valid(in_valid[0]), .in_ready(rdy0),
        .data_in(data_in[0]), .clear_underrun(clear_und[0]), .data_out(dout0),
        .out_valid(ov0), .frame_start(fs0), .underrun(ur0));

    stream_serializer #(.D(8), .S(4), .MSB_FIRST(1), .IDLE_PATTERN(8'h00)) u1 (
        .high_speed_clock(clk), .reset(reset), .in_valid(in_valid[1]), .in_ready(rdy1),
        .data_in(data_in[1]), .clear_underrun(clear_und[1]), .data_out(dout1),
        .out_valid(ov1), .frame_start(fs1), .underrun(ur1));

    stream_serializer #(.D(4), .S(3), .MSB_FIRST(0), .IDLE_PATTERN(4'h9)) u2 (
        .high_speed_clock(clk), .reset(reset), .in_valid(in_valid[2]), .in_ready(rdy2),
        .data_in(data_in[2][11:0]), .clear_underrun(clear_und[2]), .data_out(dout2),
        .out_valid(ov2), .frame_start(fs2), .underrun(ur2));

    stream_serializer #(.D(8), .S(1), .MSB_FIRST(0), .IDLE_PATTERN(8'h5A)) u3 (
        .high_speed_clock(clk), .reset(reset), .in_valid(in_valid[3]), .in_ready(rdy3),
        .data_in(data_in[3][7:0]), .clear_underrun(clear_und[3]), .data_out(dout3),
        .out_valid(ov3), .frame_start(fs3), .underrun(ur3));

    int         cfg_d    [4] = '{8, 8, 4, 8};
    int         cfg_s    [4] = '{4, 4, 3, 1};
    int         cfg_m    [4] = '{0, 1, 0, 0};
    logic [7:0] cfg_idle [4] = '{8'hA5, 8'h00, 8'h09, 8'h5A};

    typedef struct {
        logic [31:0] word;
        int          start;
    } sched_t;

    sched_t      sched    [4][$];
    logic [31:0] pend     [4][$];
    int          last_end [4];
    bit          exp_und  [4];
    bit          prev_ov  [4];
    bit          acc      [4];

    int tests  = 0;
    int fails  = 0;
    int edge_n = 0;

    task automatic check(input string tag, input int i, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s inst%0d edge%0d: observed %0h expected %0h", tag, i, edge_n, obs, exp);
        end
    endtask

    task automatic sample(input int i, output logic r, output logic [7:0] d,
                          output logic v, output logic f, output logic u);
        case (i)
            0:       begin r = rdy0; d = dout0;         v = ov0; f = fs0; u = ur0; end
            1:       begin r = rdy1; d = dout1;         v = ov1; f = fs1; u = ur1; end
            2:       begin r = rdy2; d = {4'h0, dout2}; v = ov2; f = fs2; u = ur2; end
            default: begin r = rdy3; d = dout3;         v = ov3; f = fs3; u = ur3; end
        endcase
    endtask

    function automatic logic [7:0] exp_beat(input int i, input logic [31:0] w, input int k);
        int          pos;
        logic [31:0] b;
        pos = (cfg_m[i] != 0) ? (cfg_s[i] - 1 - k) : k;
        b   = (w >> (pos * cfg_d[i])) & ((32'd1 << cfg_d[i]) - 32'd1);
        return b[7:0];
    endfunction

    // Staging is busy at the next edge iff some accepted word starts strictly after it.
    function automatic bit model_ready(input int i);
        foreach (sched[i][j]) begin
            if (sched[i][j].start > edge_n + 1) return 1'b0;
        end
        return 1'b1;
    endfunction

    task automatic model_clear();
        for (int i = 0; i < 4; i++) begin
            sched[i].delete();
            pend[i].delete();
            last_end[i] = -100;
            exp_und[i]  = 1'b0;
            prev_ov[i]  = 1'b0;
        end
    endtask

    task automatic step(input int pct);
        bit         clr_e [4];
        logic       r, v, f, u;
        logic [7:0] d;
        for (int i = 0; i < 4; i++) begin
            in_valid[i] = (pend[i].size() > 0) && ($urandom_range(99) < pct);
            data_in[i]  = in_valid[i] ? pend[i][0] : $urandom();
            sample(i, r, d, v, f, u);
            check("in_ready", i, {31'b0, r}, {31'b0, model_ready(i)});
            acc[i]   = in_valid[i] && model_ready(i);
            clr_e[i] = clear_und[i];
        end
        @(posedge clk);
        edge_n++;
        for (int i = 0; i < 4; i++) begin
            if (acc[i]) begin
                sched_t e;
                e.word      = pend[i].pop_front();
                e.start     = (edge_n + 1 > last_end[i] + 1) ? edge_n + 1 : last_end[i] + 1;
                last_end[i] = e.start + cfg_s[i] - 1;
                sched[i].push_back(e);
            end
        end
        #1;
        for (int i = 0; i < 4; i++) begin
            bit         e_ov, e_fs;
            logic [7:0] e_d;
            clear_und[i] = 1'b0;
            while (sched[i].size() > 0 && sched[i][0].start + cfg_s[i] - 1 < edge_n)
                void'(sched[i].pop_front());
            if (sched[i].size() > 0 && sched[i][0].start <= edge_n) begin
                e_ov = 1'b1;
                e_fs = (edge_n == sched[i][0].start);
                e_d  = exp_beat(i, sched[i][0].word, edge_n - sched[i][0].start);
            end else begin
                e_ov = 1'b0;
                e_fs = 1'b0;
                e_d  = cfg_idle[i];
            end
            if (prev_ov[i] && !e_ov) exp_und[i] = 1'b1;
            else if (clr_e[i])       exp_und[i] = 1'b0;
            prev_ov[i] = e_ov;
            sample(i, r, d, v, f, u);
            check("data_out",    i, {24'b0, d}, {24'b0, e_d});
            check("out_valid",   i, {31'b0, v}, {31'b0, e_ov});
            check("frame_start", i, {31'b0, f}, {31'b0, e_fs});
            check("underrun",    i, {31'b0, u}, {31'b0, exp_und[i]});
        end
    endtask

    task automatic run(input int n, input int pct);
        for (int k = 0; k < n; k++) step(pct);
    endtask

    // Reset is raised between edges so the asynchronous clear is observed before any clock.
    task automatic do_reset();
        logic       r, v, f, u;
        logic [7:0] d;
        #2;
        reset = 1'b1;
        for (int i = 0; i < 4; i++) in_valid[i] = 1'b0;
        #1;
        model_clear();
        for (int i = 0; i < 4; i++) begin
            sample(i, r, d, v, f, u);
            check("rst_data_out",    i, {24'b0, d}, {24'b0, cfg_idle[i]});
            check("rst_out_valid",   i, {31'b0, v}, 32'd0);
            check("rst_frame_start", i, {31'b0, f}, 32'd0);
            check("rst_underrun",    i, {31'b0, u}, 32'd0);
            check("rst_in_ready",    i, {31'b0, r}, 32'd1);
        end
        repeat (2) begin
            @(posedge clk);
            edge_n++;
        end
        #2;
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        for (int i = 0; i < 4; i++) begin
            in_valid[i]  = 1'b0;
            data_in[i]   = '0;
            clear_und[i] = 1'b0;
        end
        do_reset();

        // Single word on every configuration, then drain into idle and underrun.
        pend[0].push_back(32'h44332211);
        pend[1].push_back(32'h44332211);
        pend[2].push_back(32'h00000321);
        pend[3].push_back(32'h00000011);
        run(8, 100);

        // Back-to-back words with in_valid held high.
        pend[0].push_back(32'h44332211); pend[0].push_back(32'h88776655);
        pend[1].push_back(32'h44332211); pend[1].push_back(32'h88776655);
        pend[2].push_back(32'h00000321); pend[2].push_back(32'h00000654);
        pend[3].push_back(32'h000000AA); pend[3].push_back(32'h000000BB);
        run(12, 100);

        // Ratio 1: a new beat every cycle from an incrementing stream.
        for (int k = 0; k < 20; k++) pend[3].push_back(32'(k + 1));
        run(24, 100);

        // Random gaps, random data and random underrun clears.
        for (int k = 0; k < 400; k++) begin
            for (int i = 0; i < 4; i++) begin
                if (pend[i].size() < 2 && $urandom_range(3) != 0) pend[i].push_back($urandom());
                clear_und[i] = ($urandom_range(7) == 0);
            end
            step(70);
        end
        for (int i = 0; i < 4; i++) pend[i].delete();
        run(6, 100);

        // Reset lands between beats 0x22 and 0x33; nothing of that word may follow.
        pend[0].push_back(32'h44332211);
        run(3, 100);
        do_reset();
        run(6, 100);

        // Underrun sets after the drain and a clear pulse returns it to 0.
        pend[0].push_back(32'hDDCCBBAA);
        run(7, 100);
        clear_und[0] = 1'b1;
        run(2, 100);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
